// File: rtl/sobel_stream_filter.sv
// Streaming 3x3 Sobel edge filter: raster pixels in, one edge magnitude per interior window out.
// Three registered stages: window capture, gradients, magnitude/saturation/threshold.
module sobel_stream_filter #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned IMG_WIDTH   = 32
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic                   in_valid_i,
  input  logic                   sof_i,
  input  logic [PIXEL_WIDTH-1:0] pixel_i,
  input  logic [1:0]             mode_i,
  input  logic                   thr_en_i,
  input  logic [PIXEL_WIDTH-1:0] thr_i,
  output logic                   out_valid_o,
  output logic [PIXEL_WIDTH-1:0] pixel_o
);

  localparam int unsigned GW = PIXEL_WIDTH + 3;
  localparam int unsigned AW = PIXEL_WIDTH + 2;
  localparam int unsigned CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CW-1:0]          COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [PIXEL_WIDTH-1:0] PIX_MAX  = '1;

  logic [CW-1:0] col_q, cur_col_c, col_nxt_c;
  logic [1:0]    row_q, cur_row_c, row_nxt_c;
  logic          win_valid_c;

  logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb2 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] win [9];

  logic                   v0, v1;
  logic [1:0]             mode0, mode1;
  logic                   te0, te1;
  logic [PIXEL_WIDTH-1:0] thr0, thr1;
  logic signed [GW-1:0]   gx_c, gy_c, gx1, gy1;

  logic [AW-1:0]          ax_c, ay_c;
  logic [GW-1:0]          mag_c;
  logic [PIXEL_WIDTH-1:0] sat_c, res_c;

  function automatic logic signed [GW-1:0] ext(input logic [PIXEL_WIDTH-1:0] p);
    return signed'(GW'(p));
  endfunction

  function automatic logic [AW-1:0] abs_f(input logic signed [GW-1:0] v);
    logic signed [GW-1:0] n;
    n = -v;
    return v[GW-1] ? AW'(n) : AW'(v);
  endfunction

  // Coordinates of the pixel being accepted; sof forces (0,0). Row saturates at 2.
  always_comb begin
    cur_col_c = sof_i ? '0 : col_q;
    cur_row_c = sof_i ? '0 : row_q;
    col_nxt_c = cur_col_c + CW'(1);
    row_nxt_c = cur_row_c;
    if (cur_col_c == COL_LAST) begin
      col_nxt_c = '0;
      row_nxt_c = (cur_row_c == 2'd2) ? 2'd2 : cur_row_c + 2'd1;
    end
    win_valid_c = (cur_row_c == 2'd2) && (cur_col_c >= CW'(2));
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      col_q <= '0;
      row_q <= '0;
    end else if (in_valid_i) begin
      col_q <= col_nxt_c;
      row_q <= row_nxt_c;
    end
  end

  // Line buffers and window carry no reset; output gating hides stale data.
  always_ff @(posedge clk_i) begin
    if (in_valid_i) begin
      lb1[0] <= pixel_i;
      lb2[0] <= lb1[IMG_WIDTH-1];
      for (int i = 1; i < int'(IMG_WIDTH); i++) begin
        lb1[i] <= lb1[i-1];
        lb2[i] <= lb2[i-1];
      end
      win[0] <= win[1];
      win[1] <= win[2];
      win[2] <= lb2[IMG_WIDTH-1];
      win[3] <= win[4];
      win[4] <= win[5];
      win[5] <= lb1[IMG_WIDTH-1];
      win[6] <= win[7];
      win[7] <= win[8];
      win[8] <= pixel_i;
    end
  end

  always_comb begin
    gx_c = (ext(win[2]) - ext(win[0])) + ((ext(win[5]) - ext(win[3])) <<< 1)
         + (ext(win[8]) - ext(win[6]));
    gy_c = (ext(win[6]) - ext(win[0])) + ((ext(win[7]) - ext(win[1])) <<< 1)
         + (ext(win[8]) - ext(win[2]));
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      v0    <= 1'b0;
      mode0 <= '0;
      te0   <= 1'b0;
      thr0  <= '0;
      v1    <= 1'b0;
      mode1 <= '0;
      te1   <= 1'b0;
      thr1  <= '0;
      gx1   <= '0;
      gy1   <= '0;
    end else begin
      v0 <= in_valid_i && win_valid_c;
      if (in_valid_i) begin
        mode0 <= mode_i;
        te0   <= thr_en_i;
        thr0  <= thr_i;
      end
      v1    <= v0;
      mode1 <= mode0;
      te1   <= te0;
      thr1  <= thr0;
      gx1   <= gx_c;
      gy1   <= gy_c;
    end
  end

  // Magnitude select, saturation and optional binarisation.
  always_comb begin
    ax_c = abs_f(gx1);
    ay_c = abs_f(gy1);
    case (mode1)
      2'b00:   mag_c = GW'(ax_c) + GW'(ay_c);
      2'b01:   mag_c = (ax_c >= ay_c) ? GW'(ax_c) : GW'(ay_c);
      2'b10:   mag_c = GW'(ax_c);
      default: mag_c = GW'(ay_c);
    endcase
    sat_c = (mag_c > GW'(PIX_MAX)) ? PIX_MAX : PIXEL_WIDTH'(mag_c);
    res_c = sat_c;
    if (te1) res_c = (sat_c >= thr1) ? PIX_MAX : '0;
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      out_valid_o <= 1'b0;
      pixel_o     <= '0;
    end else begin
      out_valid_o <= v1;
      if (v1) pixel_o <= res_c;
    end
  end

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Scoreboard bench for sobel_stream_filter: a kernel-level reference model predicts each
// interior-window result and the edge it must appear on; a monitor pops and compares.
module tb_sobel_stream_filter;

  localparam int unsigned PW = 8;
  localparam int W = 8;
  localparam int PMAX = (1 << PW) - 1;
  localparam int KX[9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  localparam int KY[9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  logic          clk_i = 1'b0;
  logic          nreset_i;
  logic          in_valid_i;
  logic          sof_i;
  logic [PW-1:0] pixel_i;
  logic [1:0]    mode_i;
  logic          thr_en_i;
  logic [PW-1:0] thr_i;
  logic          out_valid_o;
  logic [PW-1:0] pixel_o;

  sobel_stream_filter #(.PIXEL_WIDTH(PW), .IMG_WIDTH(W)) dut (
    .clk_i       (clk_i),
    .nreset_i    (nreset_i),
    .in_valid_i  (in_valid_i),
    .sof_i       (sof_i),
    .pixel_i     (pixel_i),
    .mode_i      (mode_i),
    .thr_en_i    (thr_en_i),
    .thr_i       (thr_i),
    .out_valid_o (out_valid_o),
    .pixel_o     (pixel_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {int val; int edge_n;} exp_t;
  exp_t sb[$];

  int tests = 0, fails = 0;
  int edge_cnt = 0, pulses = 0, sat_cnt = 0, last_out = 0;
  int img[3][W];
  int mr = 0, mc = 0;

  always @(posedge clk_i) edge_cnt++;

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Sobel kernels applied to the 3x3 neighbourhood ending at (r,c).
  function automatic int ref_pixel(int r, int c, int mode, int te, int thr);
    int gx, gy, ax, ay, mag, v;
    gx = 0;
    gy = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        v = img[(r - 2 + dr) % 3][c - 2 + dc];
        gx += KX[dr*3+dc] * v;
        gy += KY[dr*3+dc] * v;
      end
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    case (mode)
      0:       mag = ax + ay;
      1:       mag = (ax > ay) ? ax : ay;
      2:       mag = ax;
      default: mag = ay;
    endcase
    if (mag > PMAX) mag = PMAX;
    if (te != 0) mag = (mag >= thr) ? PMAX : 0;
    return mag;
  endfunction

  // Output lands on the third rising edge counting the acceptance edge.
  task automatic model_accept(int pix, bit sof, int mode, int te, int thr, int acc_edge);
    exp_t e;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr % 3][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      e.val = ref_pixel(mr, mc, mode, te, thr);
      e.edge_n = acc_edge + 2;
      sb.push_back(e);
    end
    mc++;
    if (mc == W) begin
      mc = 0;
      mr++;
    end
  endtask

  task automatic send(int pix, bit sof, int mode, int te, int thr);
    @(negedge clk_i);
    in_valid_i = 1'b1;
    sof_i      = sof;
    pixel_i    = PW'(pix);
    mode_i     = 2'(mode);
    thr_en_i   = (te != 0);
    thr_i      = PW'(thr);
    model_accept(pix, sof, mode, te, thr, edge_cnt + 1);
  endtask

  // Idle cycles carry junk data and stray sof, all of which must be ignored.
  task automatic idle(int n);
    repeat (n) begin
      @(negedge clk_i);
      in_valid_i = 1'b0;
      sof_i      = 1'($urandom_range(0, 1));
      pixel_i    = PW'($urandom);
      mode_i     = 2'($urandom);
    end
  endtask

  task automatic drain();
    idle(1);
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    check("drain_queue_empty", sb.size(), 0);
  endtask

  // kind: 0 flat 100, 1 vertical step, 2 ramp, 3 random. mode<0 randomises per pixel.
  task automatic send_frame(int kind, int npix, int mode, int te, int thr, int maxgap,
                            int sw_at, int sw_mode, bit do_drain);
    int r, c, pix, m, t, th;
    for (int i = 0; i < npix; i++) begin
      r = i / W;
      c = i % W;
      case (kind)
        0:       pix = 100;
        1:       pix = (c < 4) ? 0 : 200;
        2:       pix = 10 * c + 5 * r;
        default: pix = int'($urandom_range(0, PMAX));
      endcase
      m = mode; t = te; th = thr;
      if (mode < 0) begin
        m  = int'($urandom_range(0, 3));
        t  = int'($urandom_range(0, 1));
        th = int'($urandom_range(0, PMAX));
      end
      if (sw_at >= 0 && i >= sw_at) m = sw_mode;
      send(pix, i == 0, m, t, th);
      if (maxgap > 0) idle(int'($urandom_range(0, maxgap)));
    end
    if (do_drain) drain();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (out_valid_o === 1'b1) begin
        pulses++;
        last_out = int'(pixel_o);
        if (pixel_o == PW'(PMAX)) sat_cnt++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out_valid: pulse with pixel_o=%0d at edge %0d, none expected",
                   pixel_o, edge_cnt);
        end else begin
          e = sb.pop_front();
          check("pixel_o", int'(pixel_o), e.val);
          check("out_valid_edge", edge_cnt, e.edge_n);
        end
      end
    end
  end

  initial begin : stim
    int p0, s0;
    int ramp_exp[4] = '{120, 80, 80, 40};
    nreset_i = 1'b0; in_valid_i = 1'b0; sof_i = 1'b0; pixel_i = '0;
    mode_i = '0; thr_en_i = 1'b0; thr_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_out_valid", int'(out_valid_o), 0);
    check("reset_pixel_o", int'(pixel_o), 0);
    nreset_i = 1'b1;
    idle(2);

    p0 = pulses;
    send_frame(0, 4*W, 0, 0, 0, 0, -1, 0, 1'b1);
    check("flat_pulse_count", pulses - p0, 12);
    check("flat_last_value", last_out, 0);

    for (int m = 0; m < 4; m++) begin
      s0 = sat_cnt;
      send_frame(1, 4*W, m, 0, 0, 0, -1, 0, 1'b1);
      check("step_saturated_count", sat_cnt - s0, (m == 3) ? 0 : 4);
    end

    for (int m = 0; m < 4; m++) begin
      send_frame(2, 4*W, m, 0, 0, 0, -1, 0, 1'b1);
      check("ramp_value", last_out, ramp_exp[m]);
    end
    send_frame(2, 4*W, 0, 1, 100, 0, -1, 0, 1'b1);
    check("ramp_thr_mode00", last_out, 255);
    send_frame(2, 4*W, 1, 1, 100, 0, -1, 0, 1'b1);
    check("ramp_thr_mode01", last_out, 0);

    for (int m = 0; m < 4; m++) begin
      p0 = pulses;
      send_frame(2, 4*W, m, 0, 0, 3, -1, 0, 1'b1);
      check("ramp_gaps_value", last_out, ramp_exp[m]);
      check("ramp_gaps_pulses", pulses - p0, 12);
    end

    send_frame(2, 4*W, 0, 0, 0, 0, 3*W + 4, 3, 1'b1);
    check("mode_switch_last", last_out, 40);

    // Reset in the middle of row 3 flushes the pipeline at once.
    send_frame(3, 3*W + 4, 0, 0, 0, 0, -1, 0, 1'b0);
    @(negedge clk_i);
    nreset_i = 1'b0;
    in_valid_i = 1'b0;
    #1;
    check("midreset_out_valid", int'(out_valid_o), 0);
    check("midreset_pixel_o", int'(pixel_o), 0);
    sb.delete();
    mr = 0;
    mc = 0;
    idle(3);
    nreset_i = 1'b1;
    p0 = pulses;
    send_frame(0, 4*W, 0, 0, 0, 0, -1, 0, 1'b1);
    check("post_reset_flat_pulses", pulses - p0, 12);

    // Mid-frame sof restarts gating; in-flight windows still complete.
    send_frame(3, 3*W + 5, 0, 0, 0, 0, -1, 0, 1'b0);
    send_frame(3, 5*W, -1, 0, 0, 0, -1, 0, 1'b1);

    for (int f = 0; f < 3; f++) send_frame(3, 5*W, -1, 0, 0, 2, -1, 0, 1'b1);

    idle(5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
